// File: rtl/digits_scan.sv
// Bus-attached multiplexed seven-segment driver: up to 8 hex digits with tear-free updates,
// blanking, decimal points and leading-zero suppression. Define DIGITS_PWM_EN for BRIGHT dimming.
module digits_scan #(
    parameter logic [31:0] ADDR       = 32'h0000_0000,
    parameter int          NUM_DIGITS = 8,
    parameter int          SCAN_DIV   = 1024
) (
    input  logic                  clk,
    input  logic                  W_RST,
    input  logic                  W_CYC,
    input  logic                  W_STB,
    input  logic                  W_WE,
    input  logic [31:0]           W_ADDR,
    input  logic [31:0]           W_DAT_I,
    output logic [31:0]           W_DAT_O,
    output logic                  W_ACK,
    output logic [7:0]            hex,
    output logic [NUM_DIGITS-1:0] dig
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = $clog2(SCAN_DIV);

    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    localparam logic [63:0] DATA_MASK64 = (64'h1 << (4 * NUM_DIGITS)) - 64'h1;
    localparam logic [31:0] DATA_MASK   = DATA_MASK64[31:0];
    localparam logic [31:0] DIG_MASK32  = (32'h1 << NUM_DIGITS) - 32'h1;
    localparam logic [7:0]  DIG_MASK    = DIG_MASK32[7:0];

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_CTRL   = 2'd1;
    localparam logic [1:0] OFF_BRIGHT = 2'd2;

    // Bus handshake: an access is offered while W_CYC & W_STB address this window; it is
    // accepted on the edge that raises W_ACK, which is held for exactly one cycle. Writes
    // commit on that edge and read data is valid only while W_ACK is high.
    logic        sel;
    logic        acc;
    logic        wr;
    logic [1:0]  reg_off;
    logic        shadow_wr;
    logic [31:0] rdata;

    logic        ack_q;
    logic [31:0] dat_q;

    // Staging (bus-visible) and display (scan-visible) copies
    logic        ctrl_en;
    logic [31:0] stg_data;
    logic        stg_lzs;
    logic [7:0]  stg_dp;
    logic [7:0]  stg_blank;
    logic [31:0] disp_data;
    logic        disp_lzs;
    logic [7:0]  disp_dp;
    logic [7:0]  disp_blank;
    logic        pending_q;

`ifdef DIGITS_PWM_EN
    logic [3:0]  stg_bright;
    logic [3:0]  disp_bright;
    logic [31:0] pwm_lhs;
    logic [31:0] pwm_rhs;
`endif

    logic [PW-1:0] pre_q;
    logic [IW-1:0] idx_q;
    logic          slot_end;
    logic          frame_end;

    logic [3:0]            cur_nib;
    logic                  cur_blank;
    logic                  cur_dp;
    logic                  cur_sup;
    logic                  zero_run;
    logic                  in_window;
    logic                  lit;
    logic [7:0]            hex_nxt;
    logic [NUM_DIGITS-1:0] dig_nxt;
    logic [7:0]            hex_q;
    logic [NUM_DIGITS-1:0] dig_q;

    logic unused_addr_bits;

    assign unused_addr_bits = ^W_ADDR[1:0];

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [7:0] b;
        case (n)
            4'h0: b = 8'h03;
            4'h1: b = 8'h9F;
            4'h2: b = 8'h25;
            4'h3: b = 8'h0D;
            4'h4: b = 8'h99;
            4'h5: b = 8'h49;
            4'h6: b = 8'h41;
            4'h7: b = 8'h1F;
            4'h8: b = 8'h01;
            4'h9: b = 8'h09;
            4'hA: b = 8'h11;
            4'hB: b = 8'hC1;
            4'hC: b = 8'h63;
            4'hD: b = 8'h85;
            4'hE: b = 8'h61;
            default: b = 8'h71;
        endcase
        return b[7:1];
    endfunction

    assign sel     = W_CYC & W_STB & (W_ADDR[31:4] == ADDR[31:4]);
    assign acc     = sel & ~ack_q;
    assign wr      = acc & W_WE;
    assign reg_off = W_ADDR[3:2];

`ifdef DIGITS_PWM_EN
    assign shadow_wr = wr & (reg_off != 2'd3);
`else
    assign shadow_wr = wr & ((reg_off == OFF_DATA) | (reg_off == OFF_CTRL));
`endif

    always_comb begin
        rdata = 32'h0;
        case (reg_off)
            OFF_DATA:   rdata = stg_data;
            OFF_CTRL:   rdata = {8'h00, stg_blank, stg_dp, 6'h00, stg_lzs, ctrl_en};
`ifdef DIGITS_PWM_EN
            OFF_BRIGHT: rdata = {28'h0, stg_bright};
`else
            OFF_BRIGHT: rdata = 32'h0;
`endif
            default:    rdata = {23'h0, pending_q & ctrl_en, 5'h00, 3'(idx_q)};
        endcase
    end

    always_ff @(posedge clk or negedge W_RST) begin
        if (!W_RST) begin
            ack_q <= 1'b0;
            dat_q <= 32'h0;
        end else begin
            ack_q <= acc;
            dat_q <= acc ? rdata : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge W_RST) begin
        if (!W_RST) begin
            ctrl_en    <= 1'b1;
            stg_data   <= 32'h0;
            stg_lzs    <= 1'b0;
            stg_dp     <= 8'h00;
            stg_blank  <= 8'h00;
`ifdef DIGITS_PWM_EN
            stg_bright <= 4'hF;
`endif
        end else if (wr) begin
            case (reg_off)
                OFF_DATA: stg_data <= W_DAT_I & DATA_MASK;
                OFF_CTRL: begin
                    ctrl_en   <= W_DAT_I[0];
                    stg_lzs   <= W_DAT_I[1];
                    stg_dp    <= W_DAT_I[15:8] & DIG_MASK;
                    stg_blank <= W_DAT_I[23:16] & DIG_MASK;
                end
`ifdef DIGITS_PWM_EN
                OFF_BRIGHT: stg_bright <= W_DAT_I[3:0];
`endif
                default: ;
            endcase
        end
    end

    assign slot_end  = (pre_q == PRE_MAX);
    assign frame_end = ctrl_en & slot_end & (idx_q == IDX_MAX);

    // Display copy samples staging before any same-edge write, so that write stays pending.
    always_ff @(posedge clk or negedge W_RST) begin
        if (!W_RST) begin
            disp_data   <= 32'h0;
            disp_lzs    <= 1'b0;
            disp_dp     <= 8'h00;
            disp_blank  <= 8'h00;
`ifdef DIGITS_PWM_EN
            disp_bright <= 4'hF;
`endif
            pending_q   <= 1'b0;
        end else begin
            if (!ctrl_en || frame_end) begin
                disp_data   <= stg_data;
                disp_lzs    <= stg_lzs;
                disp_dp     <= stg_dp;
                disp_blank  <= stg_blank;
`ifdef DIGITS_PWM_EN
                disp_bright <= stg_bright;
`endif
            end
            if (!ctrl_en)
                pending_q <= 1'b0;
            else if (shadow_wr)
                pending_q <= 1'b1;
            else if (frame_end)
                pending_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge W_RST) begin
        if (!W_RST) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (!ctrl_en) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (slot_end) begin
            pre_q <= '0;
            idx_q <= (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

`ifdef DIGITS_PWM_EN
    assign pwm_lhs   = 32'(pre_q) << 4;
    assign pwm_rhs   = (32'(disp_bright) + 32'd1) * 32'(SCAN_DIV);
    assign in_window = (pwm_lhs < pwm_rhs);
`else
    assign in_window = 1'b1;
`endif

    // zero_run accumulates from the top digit down: nibbles i..NUM_DIGITS-1 all zero.
    always_comb begin
        cur_nib   = 4'h0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        cur_sup   = 1'b0;
        zero_run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (disp_data[4*i +: 4] == 4'h0);
            if (idx_q == IW'(i)) begin
                cur_nib   = disp_data[4*i +: 4];
                cur_blank = disp_blank[i];
                cur_dp    = disp_dp[i];
                cur_sup   = disp_lzs & zero_run & (i != 0);
            end
        end
    end

    always_comb begin
        lit     = ctrl_en & ~cur_blank & ~cur_sup & in_window;
        hex_nxt = 8'hFF;
        dig_nxt = '1;
        if (lit)
            hex_nxt = {seg_decode(cur_nib), ~cur_dp};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (lit && (idx_q == IW'(i)))
                dig_nxt[i] = 1'b0;
        end
    end

    // hex and dig share one register stage so a digit never lights with stale segments.
    always_ff @(posedge clk or negedge W_RST) begin
        if (!W_RST) begin
            hex_q <= 8'hFF;
            dig_q <= '1;
        end else begin
            hex_q <= hex_nxt;
            dig_q <= dig_nxt;
        end
    end

    assign W_ACK   = ack_q;
    assign W_DAT_O = dat_q;
    assign hex     = hex_q;
    assign dig     = dig_q;

endmodule

// File: tb/tb_digits_scan.sv
// Directed bench for digits_scan (NUM_DIGITS=8, SCAN_DIV=16); inputs change and outputs are
// sampled on the falling clock edge.
module tb_digits_scan;

`ifdef DIGITS_PWM_EN
    localparam bit PWM = 1'b1;
`else
    localparam bit PWM = 1'b0;
`endif

    localparam logic [31:0] A_DATA   = 32'h0;
    localparam logic [31:0] A_CTRL   = 32'h4;
    localparam logic [31:0] A_BRIGHT = 32'h8;
    localparam logic [31:0] A_STATUS = 32'hC;

    logic        clk = 1'b0;
    logic        W_RST = 1'b0;
    logic        W_CYC = 1'b0;
    logic        W_STB = 1'b0;
    logic        W_WE = 1'b0;
    logic [31:0] W_ADDR = 32'h0;
    logic [31:0] W_DAT_I = 32'h0;
    logic [31:0] W_DAT_O;
    logic        W_ACK;
    logic [7:0]  hex;
    logic [7:0]  dig;

    int compared = 0;
    int mismatched = 0;

    logic [7:0]  exp_hex [8];
    logic [7:0]  lit_mask;
    int          on_cycles;
    logic [31:0] rd;

    digits_scan #(.ADDR(32'h0), .NUM_DIGITS(8), .SCAN_DIV(16)) dut (
        .clk(clk), .W_RST(W_RST), .W_CYC(W_CYC), .W_STB(W_STB), .W_WE(W_WE),
        .W_ADDR(W_ADDR), .W_DAT_I(W_DAT_I), .W_DAT_O(W_DAT_O), .W_ACK(W_ACK),
        .hex(hex), .dig(dig)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        W_CYC = 1'b1; W_STB = 1'b1; W_WE = 1'b1; W_ADDR = a; W_DAT_I = d;
        @(negedge clk);
        chk("write_ack", {31'h0, W_ACK}, 32'h1);
        W_CYC = 1'b0; W_STB = 1'b0; W_WE = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        W_CYC = 1'b1; W_STB = 1'b1; W_WE = 1'b0; W_ADDR = a;
        @(negedge clk);
        chk("read_ack", {31'h0, W_ACK}, 32'h1);
        d = W_DAT_O;
        W_CYC = 1'b0; W_STB = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_dig_is(input logic [7:0] v);
        int n = 0;
        while (dig !== v && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("wait_dig_is", {24'h0, dig}, {24'h0, v});
    endtask

    task automatic wait_dig_not(input logic [7:0] v);
        int n = 0;
        while (dig === v && n < 400) begin
            @(negedge clk);
            n++;
        end
        compared++;
        assert (dig !== v) else begin
            mismatched++;
            $error("FAIL wait_dig_not: observed %h expected not %h", dig, v);
        end
    endtask

    task automatic wait_pending_clear();
        logic [31:0] r;
        int n = 0;
        do begin
            bus_read(A_STATUS, r);
            n++;
        end while (r[8] && n < 100);
        chk("pending_clear", {31'h0, r[8]}, 32'h0);
    endtask

    // Lands on the first sample of digit 1's slot.
    task automatic sync_slot1();
        wait_dig_not(8'hFD);
        wait_dig_is(8'hFD);
    endtask

    task automatic check_frame(input int start);
        for (int s = 0; s < 8; s++) begin
            int slot;
            slot = (start + s) % 8;
            for (int c = 0; c < 16; c++) begin
                logic lit;
                logic [7:0] ed;
                logic [7:0] eh;
                lit = lit_mask[slot] && (c < on_cycles);
                ed = lit ? ~(8'h01 << slot) : 8'hFF;
                eh = lit ? exp_hex[slot] : 8'hFF;
                chk($sformatf("dig slot%0d c%0d", slot, c), {24'h0, dig}, {24'h0, ed});
                chk($sformatf("hex slot%0d c%0d", slot, c), {24'h0, hex}, {24'h0, eh});
                @(negedge clk);
            end
        end
    endtask

    initial begin
        on_cycles = 16;
        lit_mask  = 8'hFF;

        // Reset state, then release and walk one full frame of zeros.
        @(negedge clk);
        chk("rst_hex", {24'h0, hex}, 32'hFF);
        chk("rst_dig", {24'h0, dig}, 32'hFF);
        chk("rst_ack", {31'h0, W_ACK}, 32'h0);
        chk("rst_dat", W_DAT_O, 32'h0);
        W_RST = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) exp_hex[i] = 8'h03;
        check_frame(0);
        bus_read(A_DATA, rd);
        chk("data_reset", rd, 32'h0);

        // Mid-frame DATA write stays pending until the frame boundary.
        wait_dig_is(8'hEF);
        bus_write(A_DATA, 32'h89AB_CDEF);
        bus_read(A_STATUS, rd);
        chk("status_pending", {31'h0, rd[8]}, 32'h1);
        chk("status_index", {29'h0, rd[2:0]}, 32'h4);
        wait_pending_clear();
        sync_slot1();
        exp_hex[0] = 8'h71; exp_hex[1] = 8'h61; exp_hex[2] = 8'h85; exp_hex[3] = 8'h63;
        exp_hex[4] = 8'hC1; exp_hex[5] = 8'h11; exp_hex[6] = 8'h09; exp_hex[7] = 8'h01;
        check_frame(1);
        bus_read(A_STATUS, rd);
        chk("status_no_pending", {31'h0, rd[8]}, 32'h0);

        // Leading-zero suppression.
        bus_write(A_CTRL, 32'h0000_0003);
        bus_write(A_DATA, 32'h0000_0050);
        wait_pending_clear();
        sync_slot1();
        for (int i = 0; i < 8; i++) exp_hex[i] = 8'hFF;
        exp_hex[0] = 8'h03; exp_hex[1] = 8'h49;
        lit_mask = 8'h03;
        check_frame(1);

        // Blank digit 0, decimal point on digit 2.
        bus_write(A_CTRL, 32'h0001_0401);
        bus_read(A_CTRL, rd);
        chk("ctrl_readback", rd, 32'h0001_0401);
        wait_pending_clear();
        sync_slot1();
        for (int i = 0; i < 8; i++) exp_hex[i] = 8'h03;
        exp_hex[1] = 8'h49; exp_hex[2] = 8'h02;
        lit_mask = 8'hFE;
        check_frame(1);

        // Brightness register and PWM window.
        bus_write(A_BRIGHT, 32'h0000_0005);
        bus_read(A_BRIGHT, rd);
        chk("bright_readback", rd, PWM ? 32'h5 : 32'h0);
        bus_write(A_BRIGHT, 32'h0000_0000);
        bus_write(A_CTRL, 32'h0000_0001);
        wait_pending_clear();
        sync_slot1();
        exp_hex[2] = 8'h03;
        lit_mask = 8'hFF;
        on_cycles = PWM ? 1 : 16;
        check_frame(1);
        bus_write(A_BRIGHT, 32'h0000_000F);
        on_cycles = 16;

        // Held strobe acknowledges every other cycle.
        W_CYC = 1'b1; W_STB = 1'b1; W_WE = 1'b0; W_ADDR = A_DATA;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("held_ack%0d", k), {31'h0, W_ACK}, (k % 2 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("held_dat%0d", k), W_DAT_O, (k % 2 == 0) ? 32'h50 : 32'h0);
        end
        W_CYC = 1'b0; W_STB = 1'b0;
        @(negedge clk);

        // Out-of-window write: never acknowledged, no effect.
        W_CYC = 1'b1; W_STB = 1'b1; W_WE = 1'b1; W_ADDR = 32'h0000_0010; W_DAT_I = 32'hFFFF_FFFF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("oow_ack%0d", k), {31'h0, W_ACK}, 32'h0);
        end
        W_CYC = 1'b0; W_STB = 1'b0; W_WE = 1'b0;
        @(negedge clk);
        bus_read(A_DATA, rd);
        chk("oow_data", rd, 32'h50);

        // Disable mid-slot, then re-enable.
        sync_slot1();
        @(negedge clk);
        @(negedge clk);
        bus_write(A_CTRL, 32'h0000_0000);
        chk("dis_dig", {24'h0, dig}, 32'hFF);
        chk("dis_hex", {24'h0, hex}, 32'hFF);
        bus_read(A_STATUS, rd);
        chk("dis_status", rd, 32'h0);
        repeat (20) @(negedge clk);
        chk("dis_dig_hold", {24'h0, dig}, 32'hFF);
        bus_write(A_CTRL, 32'h0000_0001);
        chk("en_dig", {24'h0, dig}, 32'hFE);
        chk("en_hex", {24'h0, hex}, 32'h03);

        // Reset during an acknowledged access.
        W_CYC = 1'b1; W_STB = 1'b1; W_WE = 1'b0; W_ADDR = A_CTRL;
        @(negedge clk);
        chk("pre_rst_ack", {31'h0, W_ACK}, 32'h1);
        W_RST = 1'b0;
        #1;
        chk("mid_rst_ack", {31'h0, W_ACK}, 32'h0);
        chk("mid_rst_dat", W_DAT_O, 32'h0);
        chk("mid_rst_hex", {24'h0, hex}, 32'hFF);
        chk("mid_rst_dig", {24'h0, dig}, 32'hFF);
        @(negedge clk);
        W_CYC = 1'b0; W_STB = 1'b0;
        W_RST = 1'b1;
        @(negedge clk);
        bus_read(A_DATA, rd);
        chk("post_rst_data", rd, 32'h0);
        bus_read(A_CTRL, rd);
        chk("post_rst_ctrl", rd, 32'h1);
        bus_read(A_BRIGHT, rd);
        chk("post_rst_bright", rd, PWM ? 32'hF : 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/digits_scan.md
# digits_scan

Parametrised, bus-attached multiplexed seven-segment display driver. It holds up to 8 hex digits behind Wishbone-style register access and scans them onto shared segment lines with one-hot active-low digit enables. It adds the following on top of the fixed 8-digit scanner:
- frame-synchronous (tear-free) updates
- per-digit blanking and decimal points
- leading-zero suppression
- optional PWM dimming

It sits on the peripheral bus next to the other slave cores.

## Interface
- ADDR, 32'h0000_0000, base address; block decodes ADDR[31:4], 16-byte window
- NUM_DIGITS, 8, digits driven, 1..8
- SCAN_DIV, 1024, clk cycles per digit slot, >= 16
- clk  in  1  single clock; all logic on rising edge
- W_RST  in  1  reset, asynchronous, active-low
- W_CYC  in  1  bus cycle valid
- W_STB  in  1  strobe
- W_WE  in  1  1 = write, 0 = read
- W_ADDR  in  32  byte address
- W_DAT_I  in  32  write data
- W_DAT_O  out  32  read data, registered
- W_ACK  out  1  one-cycle acknowledge
- hex  out  8  segments, active-low: [7:1] = a..g, [0] = dp
- dig  out  NUM_DIGITS  digit enables, active-low one-hot; dig[0] = least significant digit

## Operation
- Select: W_CYC & W_STB & (W_ADDR[31:4] == ADDR[31:4]).
  - W_ACK <= select & ~W_ACK, so a held strobe gets an ACK every other cycle.
  - A write takes effect on the same edge that raises W_ACK. W_DAT_O is valid while W_ACK = 1 and is 0 otherwise.
  - Out-of-window accesses get no ACK.
- Registers (offset W_ADDR[3:2]):
  - 0 DATA: nibble i = digit i; nibbles >= NUM_DIGITS read 0.
  - 1 CTRL: [0] enable, [1] leading-zero suppress, [15:8] dp mask, [23:16] blank mask; mask bits >= NUM_DIGITS read 0.
  - 2 BRIGHT: [3:0] duty D.
  - 3 STATUS, read-only: [2:0] current digit index, [8] update pending. Writes ignored, still ACKed.
- Shadowing:
  - Bus writes to DATA, CTRL[23:1] and BRIGHT go to staging registers and set pending.
  - At each frame boundary (prescaler wrap while index = NUM_DIGITS-1), staging copies to display and pending clears.
  - A write on the same edge as a boundary: the copy uses pre-write staging; pending stays 1.
- CTRL[0] enable acts immediately.
  - While 0: prescaler and index are held at 0, staging copies to display every cycle, pending reads 0, dig is all-ones, hex = 8'hFF.
- Scan: prescaler counts 0..SCAN_DIV-1. On wrap, index advances, wrapping NUM_DIGITS-1 -> 0.
- Digit i is lit when index = i and all of the following hold:
  - it is not blanked;
  - it is not suppressed;
  - it is inside the PWM window.
- Lit digit output: dig[i] = 0; hex[7:1] = decode(nibble i); hex[0] = ~dp[i].
- Unlit slot output: dig all-ones, hex = 8'hFF.
- Decode, full hex byte with dp off:
  - 0:03, 1:9F, 2:25, 3:0D
  - 4:99, 5:49, 6:41, 7:1F
  - 8:01, 9:09, A:11, B:C1
  - C:63, D:85, E:61, F:71
- Leading-zero suppress: digit i > 0 is suppressed when display nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never suppressed. Suppression does not affect dp, but a suppressed digit shows nothing.

## Timing
- Reset values:
  - W_ACK 0, W_DAT_O 0, hex 8'hFF, dig all-ones
  - prescaler 0, index 0, pending 0
  - DATA 0 (staging and display), CTRL 32'h0000_0001, BRIGHT 4'hF
- Read/write latency: 1 cycle from select to ACK.
- hex and dig are registered and change on the same edge, exactly one cycle after index or prescaler changes. No cycle has dig asserted with stale hex.
- Frame period: NUM_DIGITS * SCAN_DIV cycles.
- With D = 15, dig[0] first goes low on cycle 1 after reset release.
- Reset asserted mid-scan or mid-access: all outputs take reset values asynchronously. An in-flight ACK is dropped.

## Configuration
- DIGITS_PWM_EN defined:
  - BRIGHT is implemented.
  - The digit is in-window iff prescaler*16 < (D+1)*SCAN_DIV. D = 15 means always on; D = 0 gives 1/16 duty.
- DIGITS_PWM_EN undefined:
  - BRIGHT reads 0 and writes are ignored (still ACKed).
  - The window is always true; no PWM comparator is built.

## Test plan
- Reset release, NUM_DIGITS=8, SCAN_DIV=16 -> DATA reads 0; dig walks FE, FD, ... 7F, 16 cycles each; hex=03 while lit.
- Write DATA=32'h89ABCDEF mid-frame -> STATUS[8]=1 until index wraps to 0. Then hex sequence for digits 0..7 is 71, 61, 85, 63, C1, 11, 09, 01 and pending reads 0.
- CTRL=32'h0000_0003, DATA=32'h0000_0050 -> digits 0,1 lit (hex 03, 49); digits 2..7 dark (dig all-ones, hex FF) during their slots.
- CTRL dp mask 8'h04, blank mask 8'h01 -> slot 0 dark; slot 2 hex bit0 = 0.
- With DIGITS_PWM_EN, BRIGHT=0, SCAN_DIV=16 -> each digit lit 1 of 16 cycles. Without the macro, BRIGHT reads 0 and the digit is lit 16/16.
- CTRL[0] cleared mid-slot -> next cycle dig all-ones, STATUS[2:0]=0. Write W_ADDR outside window -> no W_ACK for 4 cycles.
